// File: rtl/draw_sequencer_pkg.sv
// draw_sequencer_pkg: shared state encoding and pixel field widths for the draw path
package draw_sequencer_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COORD_W = X_W + Y_W;
  localparam int COLOUR_W = 9;
  localparam int PIX_W = COORD_W + COLOUR_W;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/draw_sequencer_pixel_fifo.sv
// pixel_fifo: synchronous FIFO buffering pixels between drawers and the VGA adapter
module pixel_fifo
  import draw_sequencer_pkg::*;
#(
  parameter int W = PIX_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  // pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage is left unreset; dout is masked while empty
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: starts drawers in turn each frame and owns the VGA write port
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  output logic [N_CLIENTS-1:0]          start_draw,
  input  logic [N_CLIENTS-1:0]          client_done,
  input  logic [N_CLIENTS-1:0]          client_wren,
  input  logic [COORD_W*N_CLIENTS-1:0]  client_coord,
  input  logic [COLOUR_W*N_CLIENTS-1:0] client_colour,
  output logic                          client_stall,
  output logic                          vga_plot,
  output logic [X_W-1:0]                vga_x,
  output logic [Y_W-1:0]                vga_y,
  output logic [COLOUR_W-1:0]           vga_colour,
  input  logic                          vga_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic [N_CLIENTS-1:0]          timeout_err,
  output logic                          overflow_err,
  output logic [7:0]                    frames_dropped
);
  localparam int CW = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1;
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [CW-1:0] cur;
  logic [15:0] tcnt;
  logic wren_cur, full, empty, push, pop, ovf;
  logic [NW-1:0] count;
  logic [PIX_W-1:0] pix_in, pix_out;
  assign wren_cur = state == S_WAIT && client_wren[cur];
  assign pix_in = {client_coord[COORD_W*int'(cur) +: COORD_W], client_colour[COLOUR_W*int'(cur) +: COLOUR_W]};
  assign pop = vga_plot && vga_ready;
  assign push = wren_cur && (!full || pop);
  assign ovf = wren_cur && full && !pop;
  assign vga_plot = !empty;
  assign {vga_x, vga_y, vga_colour} = pix_out;
  assign client_stall = count >= NW'(FIFO_DEPTH - 1);
  assign busy = state != S_IDLE;
  pixel_fifo #(.W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pix_in),
    .dout(pix_out), .full(full), .empty(empty), .count(count)
  );
  // frame sequencing: start pulse, wait for done or timeout, drain, next client
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cur <= '0;
      tcnt <= '0;
      start_draw <= '0;
      frame_done <= 1'b0;
      timeout_err <= '0;
      overflow_err <= 1'b0;
      frames_dropped <= '0;
    end else begin
      start_draw <= '0;
      frame_done <= 1'b0;
      if (frame_tick && busy && frames_dropped != 8'hff) frames_dropped <= frames_dropped + 8'd1;
      if (ovf) overflow_err <= 1'b1;
      case (state)
        S_IDLE:
          if (frame_tick) begin
            cur <= '0;
            start_draw <= N_CLIENTS'(1);
            state <= S_START;
          end
        S_START: begin
          tcnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (client_done[cur]) state <= S_FLUSH;
          else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
            timeout_err[cur] <= 1'b1;
            state <= S_FLUSH;
          end else tcnt <= tcnt + 16'd1;
        S_FLUSH:
          if (empty) begin
            if (cur == CW'(N_CLIENTS - 1)) begin
              frame_done <= 1'b1;
              state <= S_DONE;
            end else begin
              cur <= cur + 1'b1;
              start_draw <= N_CLIENTS'(1) << (cur + 1'b1);
              state <= S_START;
            end
          end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed table and sequence checks of the frame draw scheduler
module tb_draw_sequencer;
  logic clk = 0, reset = 1, frame_tick = 0, vga_ready = 0;
  logic [3:0] start_draw, client_done = 0, client_wren = 0, timeout_err;
  logic [59:0] client_coord = 0;
  logic [35:0] client_colour = 0;
  logic client_stall, vga_plot, busy, frame_done, overflow_err;
  logic [7:0] vga_x, frames_dropped;
  logic [6:0] vga_y;
  logic [8:0] vga_colour;
  int total = 0, bad = 0, fd_cnt = 0;
  logic [23:0] got[$], exp_q[$];
  logic [3:0] starts[$];

  typedef struct {
    logic tick;
    logic [3:0] st;
    logic bsy;
    logic fd;
  } vec_t;
  vec_t tbl[14];

  draw_sequencer #(.N_CLIENTS(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_draw(start_draw),
    .client_done(client_done), .client_wren(client_wren), .client_coord(client_coord),
    .client_colour(client_colour), .client_stall(client_stall), .vga_plot(vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_ready(vga_ready),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .overflow_err(overflow_err), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset) begin
      if (vga_plot && vga_ready) got.push_back({vga_x, vga_y, vga_colour});
      if (|start_draw) starts.push_back(start_draw);
      if (frame_done) fd_cnt++;
    end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic do_reset;
    reset = 1;
    frame_tick = 0;
    client_done = 0;
    client_wren = 0;
    step();
    step();
    reset = 0;
    step();
    got.delete();
    exp_q.delete();
    starts.delete();
    fd_cnt = 0;
  endtask

  function automatic logic [23:0] mk(input int i, input int k);
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    x = 8'(16 * i + k + 1);
    y = 7'(3 * i + k + 5);
    c = 9'(37 * i + 5 * k + 1);
    return {x, y, c};
  endfunction

  task automatic set_pix(input int i, input logic [23:0] p);
    client_coord[15*i +: 15] = p[23:9];
    client_colour[9*i +: 9] = p[8:0];
  endtask

  task automatic wait_start(input int i);
    int n = 0;
    while (!start_draw[i] && n < 60) begin
      step();
      n++;
    end
    if (!start_draw[i]) chk($sformatf("start%0d_timeout", i), 0, 1);
  endtask

  task automatic wait_frame;
    int n = 0;
    int f0 = fd_cnt;
    while (fd_cnt == f0 && n < 120) begin
      step();
      n++;
    end
    if (fd_cnt == f0) chk("frame_done_timeout", 0, 1);
    step();
  endtask

  task automatic cmp_q(input string name);
    chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int j = 0; j < got.size() && j < exp_q.size(); j++)
      chk($sformatf("%s_pix%0d", name, j), 32'(got[j]), 32'(exp_q[j]));
  endtask

  task automatic start_frame;
    frame_tick = 1;
    step();
    frame_tick = 0;
  endtask

  initial begin
    tbl[0] = '{1, 4'b0001, 1, 0};
    tbl[1] = '{0, 4'b0000, 1, 0};
    tbl[2] = '{0, 4'b0000, 1, 0};
    tbl[3] = '{0, 4'b0010, 1, 0};
    tbl[4] = '{0, 4'b0000, 1, 0};
    tbl[5] = '{0, 4'b0000, 1, 0};
    tbl[6] = '{0, 4'b0100, 1, 0};
    tbl[7] = '{0, 4'b0000, 1, 0};
    tbl[8] = '{0, 4'b0000, 1, 0};
    tbl[9] = '{0, 4'b1000, 1, 0};
    tbl[10] = '{0, 4'b0000, 1, 0};
    tbl[11] = '{0, 4'b0000, 1, 0};
    tbl[12] = '{0, 4'b0000, 1, 1};
    tbl[13] = '{0, 4'b0000, 0, 0};

    do_reset();
    chk("rst_start", 32'(start_draw), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_pix", 32'({vga_x, vga_y, vga_colour}), 0);
    chk("rst_flags", 32'({client_stall, timeout_err, overflow_err, frame_done, frames_dropped}), 0);

    vga_ready = 1;
    client_done = 4'b1111;
    for (int r = 0; r < 14; r++) begin
      frame_tick = tbl[r].tick;
      step();
      chk($sformatf("tbl%0d_start", r), 32'(start_draw), 32'(tbl[r].st));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
      chk($sformatf("tbl%0d_fd", r), 32'(frame_done), 32'(tbl[r].fd));
    end
    chk("tbl_fd_count", 32'(fd_cnt), 1);

    do_reset();
    vga_ready = 1;
    start_frame();
    for (int i = 0; i < 4; i++) begin
      wait_start(i);
      step();
      for (int k = 0; k < 3; k++) begin
        set_pix(i, mk(i, k));
        exp_q.push_back(mk(i, k));
        client_wren[i] = 1;
        client_done[i] = k == 2;
        step();
      end
      client_wren = 0;
      client_done = 0;
    end
    wait_frame();
    cmp_q("frame");
    chk("frame_starts_len", 32'(starts.size()), 4);
    for (int j = 0; j < starts.size() && j < 4; j++)
      chk($sformatf("frame_start%0d", j), 32'(starts[j]), 32'(1 << j));
    chk("frame_fd_count", 32'(fd_cnt), 1);

    do_reset();
    vga_ready = 0;
    client_done = 4'b1110;
    start_frame();
    wait_start(0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_nostall%0d", k), 32'(client_stall), 0);
      set_pix(0, mk(0, k));
      exp_q.push_back(mk(0, k));
      client_wren[0] = 1;
      step();
    end
    client_wren = 0;
    chk("bp_stall", 32'(client_stall), 1);
    step();
    chk("bp_stall_hold", 32'(client_stall), 1);
    vga_ready = 1;
    step();
    chk("bp_stall_release", 32'(client_stall), 0);
    set_pix(0, mk(0, 3));
    exp_q.push_back(mk(0, 3));
    client_wren[0] = 1;
    client_done[0] = 1;
    step();
    client_wren = 0;
    wait_frame();
    chk("bp_no_ovf", 32'(overflow_err), 0);
    cmp_q("bp");

    do_reset();
    vga_ready = 0;
    client_done = 4'b1110;
    start_frame();
    wait_start(0);
    step();
    for (int k = 0; k < 6; k++) begin
      set_pix(0, mk(0, k));
      if (k < 4) exp_q.push_back(mk(0, k));
      client_wren[0] = 1;
      client_done[0] = k == 5;
      step();
      if (k == 3) chk("ovf_clear_at_full", 32'(overflow_err), 0);
    end
    client_wren = 0;
    chk("ovf_set", 32'(overflow_err), 1);
    vga_ready = 1;
    wait_frame();
    cmp_q("ovf");

    do_reset();
    vga_ready = 1;
    client_done = 4'b1101;
    start_frame();
    wait_start(1);
    begin
      int n = 0;
      step();
      n = 1;
      while (!start_draw[2] && n < 40) begin
        step();
        n++;
      end
      chk("to_start2_delay", 32'(n), 18);
    end
    chk("to_err", 32'(timeout_err), 4'b0010);
    wait_frame();
    chk("to_err_sticky", 32'(timeout_err), 4'b0010);

    do_reset();
    vga_ready = 1;
    start_frame();
    wait_start(0);
    step();
    set_pix(2, 24'hABCDEF);
    client_wren = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      frame_tick = k % 2 == 0;
      step();
    end
    frame_tick = 0;
    client_wren = 0;
    client_done = 4'b1111;
    wait_frame();
    chk("drop_count", 32'(frames_dropped), 3);
    chk("foreign_none", 32'(got.size()), 0);

    do_reset();
    vga_ready = 0;
    start_frame();
    wait_start(0);
    step();
    for (int k = 0; k < 2; k++) begin
      set_pix(0, mk(0, k));
      client_wren[0] = 1;
      step();
    end
    client_wren = 0;
    chk("mid_plot_before", 32'(vga_plot), 1);
    reset = 1;
    step();
    chk("mid_plot", 32'(vga_plot), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_flags", 32'({client_stall, timeout_err, overflow_err, frame_done, start_draw, frames_dropped}), 0);
    reset = 0;
    step();
    chk("mid_no_fd", 32'(fd_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-level draw scheduler and VGA write-port owner for the game display path. On each frame tick it starts the pixel drawers (background, towers, cars, laser chain) one at a time with a one-cycle start pulse, accepts the active drawer's `wren`/`coord`/`colour` stream into a small FIFO, and forwards pixels to the VGA adapter under a valid/ready handshake. It is the receiving end of the start/done + pixel-write protocol that the drawer blocks, including the laser group, initiate.

## Interface
- `N_CLIENTS`, 4: number of drawers. Index 0 is started first.
- `FIFO_DEPTH`, 4: pixel FIFO entries. Must be a power of two, ≥4.
- `TIMEOUT_CYCLES`, 65535: maximum cycles allowed in WAIT per client. 16-bit.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle frame start request.
- `start_draw`  out  N_CLIENTS  one-hot, one-cycle start pulse to a drawer.
- `client_done`  in  N_CLIENTS  drawer finished. Level or pulse.
- `client_wren`  in  N_CLIENTS  pixel write strobe per drawer.
- `client_coord`  in  15*N_CLIENTS  packed per client as {x[7:0], y[6:0]}. Client i occupies [15i+14:15i].
- `client_colour`  in  9*N_CLIENTS  packed 9-bit colour per client.
- `client_stall`  out  1  drawers must hold and not write while high.
- `vga_plot`  out  1  pixel valid to the adapter.
- `vga_x`  out  8, `vga_y`  out  7, `vga_colour`  out  9  pixel at the FIFO head.
- `vga_ready`  in  1  adapter accepts the pixel this cycle.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the frame completes.
- `timeout_err`  out  N_CLIENTS  sticky. Client i timed out.
- `overflow_err`  out  1  sticky. A write arrived while the FIFO was full.
- `frames_dropped`  out  8  saturating count of `frame_tick` pulses seen while `busy`.

## Operation
- FSM states: IDLE, START, WAIT, FLUSH, DONE. A client index register `cur` runs from 0 to N_CLIENTS-1.
- IDLE: on `frame_tick`, set `cur`=0 and go to START.
- START: one cycle. Drive `start_draw[cur]`=1 and clear the timeout counter. Go to WAIT.
- WAIT:
  - Push a pixel when `client_wren[cur]` is high and the FIFO is not full.
  - If `client_wren[cur]` is high and the FIFO is full, drop the pixel and set `overflow_err`.
  - `client_wren` from non-current clients is ignored.
  - When `client_done[cur]` is high, go to FLUSH. A pixel written in the same cycle as done is still accepted.
  - When the counter reaches `TIMEOUT_CYCLES-1`, set `timeout_err[cur]` and go to FLUSH.
- FLUSH: wait until the FIFO is empty.
  - If `cur`=N_CLIENTS-1, go to DONE.
  - Otherwise increment `cur` and go to START.
- DONE: one cycle with `frame_done`=1, then go to IDLE.
- `client_done` is ignored in every state except WAIT.
- A `frame_tick` while `busy` is ignored and increments `frames_dropped`, saturating at 255.
- Drain side:
  - `vga_plot` = FIFO not empty.
  - `vga_x`, `vga_y`, `vga_colour` show the head entry.
  - The head is popped when `vga_plot` and `vga_ready` are both high.
  - When the FIFO is full, a pop and a push may occur in the same cycle; this is legal, and the push is not counted as overflow.
- `client_stall` is combinational: high when the FIFO count is ≥ FIFO_DEPTH-1.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - FSM in IDLE.
  - `start_draw`=0, `busy`=0, `frame_done`=0.
  - FIFO empty, so `vga_plot`=0; `vga_x`, `vga_y`, `vga_colour` are 0.
  - `client_stall`=0, `timeout_err`=0, `overflow_err`=0, `frames_dropped`=0.
- Reset asserted mid-frame aborts immediately and discards FIFO contents. No `frame_done` is produced.
- Latencies:
  - `frame_tick` at edge t gives `start_draw[0]` in cycle t+1.
  - A pixel pushed at edge t is visible on `vga_plot` in cycle t+1.
  - `client_done` at edge t with the FIFO already empty gives the next `start_draw` 2 cycles later.
- Minimum frame length with N_CLIENTS=4 and every drawer done immediately: 1 + 4×3 + 1 cycles, IDLE to IDLE.

## Structure
- Shared package holds:
  - FSM state encoding.
  - Coordinate field widths (X_W=8, Y_W=7, COORD_W=15) and COLOUR_W=9.
- One sub-module, `pixel_fifo`: a synchronous FIFO with push/pop/full/empty/count, parameterised by width (24) and depth.
- The FSM, client multiplexing, timeout counter and error flags live in `draw_sequencer`.

## Test plan
- Single frame, all clients writing:
  - Stimulus: N=4, `vga_ready`=1, each client writes 3 pixels then asserts done.
  - Expected: `start_draw` pulses 0001, 0010, 0100, 1000 in order; 12 `vga_plot` cycles with coordinates in order; one `frame_done`.
- Backpressure:
  - Stimulus: `vga_ready`=0 while client 0 writes every cycle it is not stalled.
  - Expected: `client_stall` rises when count reaches 3; no `overflow_err`; after `vga_ready`=1, 4 pixels drain in order.
- Overflow:
  - Stimulus: client 0 ignores stall and writes 6 pixels with `vga_ready`=0.
  - Expected: `overflow_err`=1; only the first 4 pixels are emitted.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; client 1 never asserts done.
  - Expected: `timeout_err`=0010; client 2 is started 16 cycles after WAIT entry plus flush time.
- Dropped frames and foreign writes:
  - Stimulus: `frame_tick` pulsed 3 times while busy; client 2 asserts wren while client 0 is active.
  - Expected: `frames_dropped`=3; client 2's pixel never appears.
- Reset mid-frame:
  - Stimulus: assert `reset` in WAIT with 2 pixels in the FIFO.
  - Expected: next cycle `vga_plot`=0 and `busy`=0; all flags clear.
